mem_responder: RTL and testbench

//  Responder end of the core's single-outstanding memory request protocol (request_enable/req_* ->

---
 rtl/mem_responder_pkg.sv | 21 ++
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder_bram_be.sv | 29 ++
 rtl/mem_responder.sv | 170 +++++++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: request modes, FSM states and
// the byte-address to word-index helper.
package mem_responder_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    MR_IDLE    = 2'd0,
    MR_ACCESS  = 2'd1,
    MR_RESPOND = 2'd2
  } memresp_state_t;

  // Unsigned 32-bit subtraction: addresses below the base wrap to huge indices
  // and therefore fall outside the window.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                             input logic [31:0] base);
    return (byte_addr - base) >> 2'd2;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the MMU (master) and the memory responder (slave).
interface mem_responder_if;
  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        access_fault;
  logic        busy;
  logic        protocol_error;

  modport master (
    output request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    input  response_enable, resp_data, access_fault, busy, protocol_error
  );

  modport slave (
    input  request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    output response_enable, resp_data, access_fault, busy, protocol_error
  );
endinterface

// File: rtl/mem_responder_bram_be.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port;
// written in the shape synthesis maps onto block RAM.
module bram_be #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  output logic [31:0]           dout
);
  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  logic [31:0] r_mem [DEPTH];

  // Read-first port: dout only moves on an enabled cycle, so it holds between accesses.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          r_mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
      dout <= r_mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Responder end of the single-outstanding memory protocol: one read or byte-strobed
// write per request against a local RAM, answered exactly LATENCY cycles later.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned LATENCY    = 2
) (
  input  logic           clk,
  input  logic           rstn,
  mem_responder_if.slave bus
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 32'd1);

  memresp_state_t        r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_in_range;
  logic                  r_rd_ok;
  logic                  r_busy, w_busy_nxt;
  logic                  r_resp_en, w_resp_en_nxt;
  logic                  r_fault, w_fault_nxt;
  logic                  r_perr, w_perr_nxt;
  logic [31:0]           r_hold, w_hold_nxt;
  logic [31:0]           w_resp_data;

  logic                  w_accept;
  logic [31:0]           w_word_idx;
  logic                  w_in_range;
  logic                  w_first_access;

  logic                  w_ram_en;
  logic [3:0]            w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [31:0]           w_ram_din;
  logic [31:0]           w_ram_dout;

  assign w_accept       = bus.request_enable && (r_state == MR_IDLE);
  assign w_word_idx     = word_index(bus.req_addr, BASE_ADDR);
  assign w_in_range     = ((w_word_idx >> ADDR_WIDTH) == 32'd0);
  assign w_first_access = (r_state == MR_ACCESS) && (r_cnt == LAT_M1);

  // With LATENCY 1 the RAM is driven straight from the request so the op lands
  // in the accepting cycle; otherwise it is issued from the latched request.
  always_comb begin
    w_ram_en   = 1'b0;
    w_ram_we   = 4'd0;
    w_ram_addr = r_addr;
    w_ram_din  = r_wdata;
    if (LATENCY == 32'd1) begin
      w_ram_en   = w_accept;
      w_ram_we   = ((bus.req_mode == MEMREQ_WRITE) && w_in_range) ? bus.req_wstrb : 4'd0;
      w_ram_addr = w_word_idx[ADDR_WIDTH-1:0];
      w_ram_din  = bus.req_wdata;
    end else begin
      w_ram_en   = w_first_access;
      w_ram_we   = ((r_mode == MEMREQ_WRITE) && r_in_range) ? r_wstrb : 4'd0;
      w_ram_addr = r_addr;
      w_ram_din  = r_wdata;
    end
  end

  // RAM dout is valid throughout RESPOND; afterwards the captured copy is shown.
  assign w_resp_data = (r_state == MR_RESPOND) ? (r_rd_ok ? w_ram_dout : 32'd0) : r_hold;

  // Next-state and output-register values.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_resp_en_nxt = 1'b0;
    w_fault_nxt   = r_fault;
    w_hold_nxt    = r_hold;
    w_perr_nxt    = r_perr | (bus.request_enable & r_busy);
    case (r_state)
      MR_IDLE: begin
        if (bus.request_enable) begin
          w_busy_nxt = 1'b1;
          w_cnt_nxt  = LAT_M1;
          if (LATENCY == 32'd1) begin
            w_state_nxt   = MR_RESPOND;
            w_resp_en_nxt = 1'b1;
            w_fault_nxt   = ~w_in_range;
          end else begin
            w_state_nxt = MR_ACCESS;
          end
        end else begin
          w_state_nxt = MR_IDLE;
        end
      end
      MR_ACCESS: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt   = MR_RESPOND;
          w_resp_en_nxt = 1'b1;
          w_fault_nxt   = ~r_in_range;
        end else begin
          w_state_nxt = MR_ACCESS;
        end
      end
      MR_RESPOND: begin
        w_state_nxt = MR_IDLE;
        w_busy_nxt  = 1'b0;
        w_hold_nxt  = w_resp_data;
      end
      default: begin
        w_state_nxt = MR_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter, request capture and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= MR_IDLE;
      r_cnt      <= 4'd0;
      r_mode     <= MEMREQ_READ;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
      r_in_range <= 1'b0;
      r_rd_ok    <= 1'b0;
      r_busy     <= 1'b0;
      r_resp_en  <= 1'b0;
      r_fault    <= 1'b0;
      r_perr     <= 1'b0;
      r_hold     <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_resp_en <= w_resp_en_nxt;
      r_fault   <= w_fault_nxt;
      r_perr    <= w_perr_nxt;
      r_hold    <= w_hold_nxt;
      if (w_accept) begin
        r_mode     <= bus.req_mode;
        r_addr     <= w_word_idx[ADDR_WIDTH-1:0];
        r_wdata    <= bus.req_wdata;
        r_wstrb    <= bus.req_wstrb;
        r_in_range <= w_in_range;
        r_rd_ok    <= (bus.req_mode == MEMREQ_READ) && w_in_range;
      end
    end
  end

  assign bus.response_enable = r_resp_en;
  assign bus.resp_data       = w_resp_data;
  assign bus.access_fault    = r_fault;
  assign bus.busy            = r_busy;
  assign bus.protocol_error  = r_perr;

  bram_be #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (w_ram_en),
    .we   (w_ram_we),
    .addr (w_ram_addr),
    .din  (w_ram_din),
    .dout (w_ram_dout)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances (LATENCY 1, 2, 3, 15) with a
// scoreboard of expected responses checked against each response pulse.
module tb_mem_responder;

  localparam int unsigned LATS [4] = '{32'd1, 32'd2, 32'd3, 32'd15};
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  typedef struct {
    int          lane;
    logic [31:0] data;
    logic        fault;
    int          due;
  } exp_t;

  logic        clk;
  logic        rstn_v    [4];
  logic        req_en    [4];
  logic        req_mode  [4];
  logic [31:0] req_addr  [4];
  logic [31:0] req_wdata [4];
  logic [3:0]  req_wstrb [4];

  wire  [3:0]  rsp_en;
  wire  [31:0] rsp_data [4];
  wire  [3:0]  fault;
  wire  [3:0]  busy;
  wire  [3:0]  perr;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] mdl [int];
  logic [31:0] last_data  [4];
  logic        last_fault [4];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    mem_responder_if bus ();
    assign bus.request_enable = req_en[g];
    assign bus.req_mode       = req_mode[g];
    assign bus.req_addr       = req_addr[g];
    assign bus.req_wdata      = req_wdata[g];
    assign bus.req_wstrb      = req_wstrb[g];
    assign rsp_en[g]          = bus.response_enable;
    assign rsp_data[g]        = bus.resp_data;
    assign fault[g]           = bus.access_fault;
    assign busy[g]            = bus.busy;
    assign perr[g]            = bus.protocol_error;

    mem_responder #(
      .ADDR_WIDTH (14),
      .BASE_ADDR  (32'h0000_0000),
      .LATENCY    (LATS[g])
    ) dut (
      .clk  (clk),
      .rstn (rstn_v[g]),
      .bus  (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return a < 32'h0001_0000;
  endfunction

  // Drive one request for one cycle; when track is set, predict its response.
  task automatic send(input int l, input logic mode, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input bit track);
    exp_t        e;
    int          key;
    logic [31:0] w;
    key     = l * 65536 + int'(a[15:2]);
    e.lane  = l;
    e.due   = cyc + int'(LATS[l]);
    e.fault = !in_win(a);
    e.data  = 32'd0;
    if (track) begin
      if (mode == RD && in_win(a)) begin
        e.data = mdl.exists(key) ? mdl[key] : 32'd0;
      end
      if (mode == WR && in_win(a)) begin
        w = mdl.exists(key) ? mdl[key] : 32'd0;
        for (int b = 0; b < 4; b++) begin
          if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
        end
        mdl[key] = w;
      end
      sb.push_back(e);
      last_data[l]  = e.data;
      last_fault[l] = e.fault;
    end
    req_en[l]    = 1'b1;
    req_mode[l]  = mode;
    req_addr[l]  = a;
    req_wdata[l] = wd;
    req_wstrb[l] = st;
    tick(1);
    req_en[l]    = 1'b0;
    req_mode[l]  = 1'($urandom);
    req_addr[l]  = $urandom;
    req_wdata[l] = $urandom;
    req_wstrb[l] = 4'($urandom);
  endtask

  task automatic wait_idle(input int l);
    int budget;
    budget = 0;
    while ((sb.size() != 0 || busy[l] !== 1'b0) && budget < 64) begin
      tick(1);
      budget++;
    end
    n_vec++;
    assert (sb.size() == 0 && busy[l] === 1'b0) else begin
      n_err++;
      $error("FAIL idle_timeout lane=%0d observed pending=%0d busy=%b expected pending=0 busy=0",
             l, sb.size(), busy[l]);
    end
  endtask

  task automatic chk_hold(input int l);
    chk("data_hold", rsp_data[l], last_data[l]);
    chk("fault_hold", 32'(fault[l]), 32'(last_fault[l]));
  endtask

  task automatic chk_quiet(input int l, input string tag);
    chk({tag, "_resp_en"}, 32'(rsp_en[l]), 32'd0);
    chk({tag, "_resp_data"}, rsp_data[l], 32'd0);
    chk({tag, "_fault"}, 32'(fault[l]), 32'd0);
    chk({tag, "_busy"}, 32'(busy[l]), 32'd0);
    chk({tag, "_perr"}, 32'(perr[l]), 32'd0);
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (rsp_en[d] === 1'b1) begin
        n_vec++;
        assert (sb.size() > 0) else begin
          n_err++;
          $error("FAIL unexpected_response lane=%0d cycle=%0d observed=1 expected=0", d, cyc);
        end
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("resp_lane", 32'(d), 32'(mon_e.lane));
          chk("resp_cycle", 32'(cyc), 32'(mon_e.due));
          chk("resp_data", rsp_data[d], mon_e.data);
          chk("resp_fault", 32'(fault[d]), 32'(mon_e.fault));
          chk("busy_at_resp", 32'(busy[d]), 32'd1);
        end
      end
    end
  end

  initial begin
    for (int l = 0; l < 4; l++) begin
      rstn_v[l] = 1'b0; req_en[l] = 1'b0; req_mode[l] = RD;
      req_addr[l] = 32'd0; req_wdata[l] = 32'd0; req_wstrb[l] = 4'd0;
      last_data[l] = 32'd0; last_fault[l] = 1'b0;
    end
    tick(3);
    for (int l = 0; l < 4; l++) chk_quiet(l, "reset");
    for (int l = 0; l < 4; l++) rstn_v[l] = 1'b1;
    tick(2);

    // LATENCY 2: full write, read back, strobed merge, empty strobe.
    send(1, WR, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b1);
    chk("busy_inflight", 32'(busy[1]), 32'd1);
    wait_idle(1);
    send(1, RD, 32'h0000_0100, 32'd0, 4'h0, 1'b1); wait_idle(1); chk_hold(1);
    send(1, WR, 32'h0000_0100, 32'h1122_3344, 4'b0101, 1'b1); wait_idle(1);
    send(1, RD, 32'h0000_0100, 32'd0, 4'h0, 1'b1); wait_idle(1); chk_hold(1);
    send(1, WR, 32'h0000_0100, 32'hFFFF_FFFF, 4'b0000, 1'b1); wait_idle(1);
    send(1, RD, 32'h0000_0100, 32'd0, 4'h0, 1'b1); wait_idle(1);

    // Out-of-window accesses fault and must not alias onto word 0.
    send(1, WR, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b1); wait_idle(1);
    send(1, RD, 32'h0001_0000, 32'd0, 4'h0, 1'b1); wait_idle(1); chk_hold(1);
    send(1, WR, 32'h0001_0000, 32'h5555_5555, 4'hF, 1'b1); wait_idle(1);
    send(1, RD, 32'h0000_0000, 32'd0, 4'h0, 1'b1); wait_idle(1); chk_hold(1);
    send(1, RD, 32'hFFFF_FFFC, 32'd0, 4'h0, 1'b1); wait_idle(1);
    chk("perr_clean", 32'(perr[1]), 32'd0);

    // Second request one cycle into the first: ignored, error flagged, one response.
    send(1, RD, 32'h0000_0100, 32'd0, 4'h0, 1'b1);
    req_en[1] = 1'b1; req_mode[1] = WR; req_addr[1] = 32'h0000_0100;
    req_wdata[1] = 32'h0000_0000; req_wstrb[1] = 4'hF;
    tick(1);
    req_en[1] = 1'b0;
    wait_idle(1);
    chk("perr_set", 32'(perr[1]), 32'd1);
    send(1, RD, 32'h0000_0100, 32'd0, 4'h0, 1'b1); wait_idle(1);
    chk("perr_sticky", 32'(perr[1]), 32'd1);

    // LATENCY 3: reset one cycle after a read is accepted drops it.
    send(2, WR, 32'h0000_0200, 32'hA5A5_5A5A, 4'hF, 1'b1); wait_idle(2);
    send(2, RD, 32'h0000_0200, 32'd0, 4'h0, 1'b1); wait_idle(2); chk_hold(2);
    send(2, RD, 32'h0000_0200, 32'd0, 4'h0, 1'b0);
    rstn_v[2] = 1'b0;
    tick(2);
    chk_quiet(2, "midreset");
    rstn_v[2] = 1'b1;
    tick(8);
    chk_quiet(2, "after_reset");
    send(2, RD, 32'h0000_0200, 32'd0, 4'h0, 1'b1); wait_idle(2);

    // LATENCY 1 and 15: second request at the earliest legal cycle.
    for (int k = 0; k < 2; k++) begin
      automatic int l = (k == 0) ? 0 : 3;
      send(l, WR, 32'h0000_0300, 32'h0BAD_F00D + 32'(l), 4'hF, 1'b1);
      tick(int'(LATS[l]));
      send(l, RD, 32'h0000_0300, 32'd0, 4'h0, 1'b1);
      tick(int'(LATS[l]));
      send(l, WR, 32'h0000_0300, 32'h7700_0066, 4'b1001, 1'b1);
      tick(int'(LATS[l]));
      send(l, RD, 32'h0000_0300, 32'd0, 4'h0, 1'b1);
      wait_idle(l);
      chk_hold(l);
      chk("perr_b2b", 32'(perr[l]), 32'd0);
    end

    tick(5);
    n_vec++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL missing_responses observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
